// File: rtl/deconv_pkg.sv
// Shared sizing and state encoding for the deconv engine readout path.
// Map geometry is fixed here so the engine and readout agree on address layout.
package deconv_pkg;
   localparam int N          = 2;
   localparam int K          = 3;
   localparam int PIXEL_BITS = 8;
   localparam int OUT_DIM    = N * K;
   localparam int ADDR_W     = $clog2(OUT_DIM * OUT_DIM);
   localparam int COORD_W    = $clog2(OUT_DIM);
   localparam int SHIFT_W    = $clog2(PIXEL_BITS);

   localparam logic [COORD_W-1:0] COORD_LAST = COORD_W'(OUT_DIM - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_SEND  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      FETCH = ST_FETCH,
      SEND  = ST_SEND,
      DONE  = ST_DONE
   } stream_state_t;
endpackage

// File: rtl/raster_counter.sv
// Raster-order row/col walker over an OUT_DIM x OUT_DIM map.
// Keeps the linear address alongside the coordinates so no multiplier is needed.
module raster_counter
   import deconv_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               advance,
   output logic [COORD_W-1:0] row,
   output logic [COORD_W-1:0] col,
   output logic [ADDR_W-1:0]  addr,
   output logic               last
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         row  <= '0;
         col  <= '0;
         addr <= '0;
      end else if (advance) begin
         addr <= addr + 1'b1;
         if (col == COORD_LAST) begin
            col <= '0;
            row <= (row == COORD_LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (row == COORD_LAST) && (col == COORD_LAST);

endmodule

// File: rtl/deconv_result_streamer.sv
// Reads the deconv result RAM in raster order after engine done and streams
// each shifted pixel with row/col tags on a valid/ready interface.
//
//   state | meaning
//   IDLE  | waiting for start (engine done)
//   FETCH | rd_addr settled; capture rd_data into the output register
//   SEND  | word presented; hold until m_ready
//   DONE  | last word accepted; frame_done pulses next cycle
module deconv_result_streamer
   import deconv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SHIFT_W-1:0]    shift,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [PIXEL_BITS-1:0] rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [PIXEL_BITS-1:0] m_data,
   output logic [COORD_W-1:0]    m_row,
   output logic [COORD_W-1:0]    m_col,
   output logic                  m_last,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  overrun
);

   stream_state_t state_q, state_d;
   logic [SHIFT_W-1:0] shift_q;
   logic               clear, advance, load;
   logic [COORD_W-1:0] row, col;
   logic               last;

   raster_counter u_raster (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .advance (advance),
      .row     (row),
      .col     (col),
      .addr    (rd_addr),
      .last    (last)
   );

   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      advance = 1'b0;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               clear   = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            load    = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (m_valid && m_ready) begin
               advance = !m_last;
               state_d = m_last ? DONE : FETCH;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_row      <= '0;
         m_col      <= '0;
         m_last     <= 1'b0;
         frame_done <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_done <= (state_q == DONE);
         overrun    <= start && (state_q != IDLE);
         if (clear) shift_q <= shift;
         if (load) begin
            m_data  <= rd_data >> shift_q;
            m_row   <= row;
            m_col   <= col;
            m_last  <= last;
            m_valid <= 1'b1;
         end else if (state_q == SEND && m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule
